// File: rtl/reset_pulse_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : reset_pulse_sequencer
// Brief    : Produces a registered reset pulse, then a registered clear window,
//            with request/done valid-ready handshakes. Optional RECOVER phase
//            is built when RESET_PULSE_SEQUENCER_RECOVERY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module reset_pulse_sequencer #(
    parameter int PULSE_CYCLES    = 4,
    parameter int RECOVERY_CYCLES = 8,
    parameter int COUNTER_WIDTH   = 8
) (
    input  logic clock,
    input  logic clear,
    input  logic request_valid,
    output logic request_ready,
    output logic reset_out,
    output logic clear_out,
    output logic done_valid,
    input  logic done_ready,
    output logic busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ASSERT  = 2'd1,
        S_RECOVER = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [COUNTER_WIDTH-1:0] c_PULSE_LOAD = COUNTER_WIDTH'(PULSE_CYCLES - 1);

    // Out-of-range counts would make the down-counter wrap; refuse to elaborate.
    if ((PULSE_CYCLES < 1) || (RECOVERY_CYCLES < 1) ||
        ((PULSE_CYCLES - 1) >= (1 << COUNTER_WIDTH)) ||
        ((RECOVERY_CYCLES - 1) >= (1 << COUNTER_WIDTH))) begin : g_bad_params
        $error("reset_pulse_sequencer: cycle counts out of range for COUNTER_WIDTH");
    end

    state_t                   r_state     = S_IDLE;
    logic [COUNTER_WIDTH-1:0] r_count     = '0;
    logic                     r_reset_out = 1'b0;

    state_t                   w_state_next;
    logic [COUNTER_WIDTH-1:0] w_count_next;

`ifdef RESET_PULSE_SEQUENCER_RECOVERY_EN
    localparam logic [COUNTER_WIDTH-1:0] c_RECOVERY_LOAD = COUNTER_WIDTH'(RECOVERY_CYCLES - 1);
    logic                     r_clear_out = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        case (r_state)
            S_IDLE: begin
                if (request_valid) begin
                    w_state_next = S_ASSERT;
                    w_count_next = c_PULSE_LOAD;
                end
            end
            S_ASSERT: begin
                if (r_count == '0) begin
`ifdef RESET_PULSE_SEQUENCER_RECOVERY_EN
                    w_state_next = S_RECOVER;
                    w_count_next = c_RECOVERY_LOAD;
`else
                    w_state_next = S_DONE;
`endif
                end else begin
                    w_count_next = r_count - 1'b1;
                end
            end
`ifdef RESET_PULSE_SEQUENCER_RECOVERY_EN
            S_RECOVER: begin
                if (r_count == '0) begin
                    w_state_next = S_DONE;
                end else begin
                    w_count_next = r_count - 1'b1;
                end
            end
`endif
            S_DONE: begin
                if (done_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_count_next = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they align with the state edge.
    always_ff @(posedge clock) begin
        if (clear) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_reset_out <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_count     <= w_count_next;
            r_reset_out <= (w_state_next == S_ASSERT);
        end
    end

`ifdef RESET_PULSE_SEQUENCER_RECOVERY_EN
    always_ff @(posedge clock) begin
        if (clear) begin
            r_clear_out <= 1'b0;
        end else begin
            r_clear_out <= (w_state_next == S_RECOVER);
        end
    end
    assign clear_out = r_clear_out;
`else
    assign clear_out = 1'b0;
`endif

    assign reset_out     = r_reset_out;
    assign request_ready = (r_state == S_IDLE) && !clear;
    assign done_valid    = (r_state == S_DONE);
    assign busy          = (r_state != S_IDLE);

endmodule
`default_nettype wire
